// File: rtl/nmi_requester_if.sv
// rtl/nmi_requester_if.sv - NMI request/acknowledge handshake between requester and core
interface nmi_requester_if;
    logic       NMI;
    logic [1:0] NMI_ID;
    logic       NMI_ACK;

    modport master (output NMI, output NMI_ID, input NMI_ACK);
    modport slave  (input NMI, input NMI_ID, output NMI_ACK);
endinterface

// File: rtl/nmi_requester.sv
// rtl/nmi_requester.sv - synchronise, debounce and prioritise four event sources onto the core NMI handshake
module nmi_requester #(
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           irq_src_i,
    input  logic [3:0]           irq_mask_i,
    input  logic                 ovf_clr_i,
    nmi_requester_if.master      nmi_if,
    output logic [3:0]           pending_o,
    output logic [3:0]           overflow_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_e;

    state_e     state_q, state_d;
    logic [3:0] src_s1_q, src_s2_q;
    logic [3:0] filt, filt_prev_q;
    logic [3:0] mask_s1_q, mask_s2_q, mask_d1_q, mask_q;
    logic       ack_s1_q, ack_s2_q, ack_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] overflow_q, overflow_d;
    logic       nmi_q, nmi_d;
    logic [1:0] nmi_id_q, nmi_id_d;
    logic [3:0] rise, cand, clr;
    logic [1:0] sel;

    // The mask runs through as many stages as a request, so a source and its
    // mask change reach the selection logic on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_s1_q    <= '0;
            src_s2_q    <= '0;
            filt_prev_q <= '0;
            mask_s1_q   <= '0;
            mask_s2_q   <= '0;
            mask_d1_q   <= '0;
            mask_q      <= '0;
            ack_s1_q    <= 1'b0;
            ack_s2_q    <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            src_s1_q    <= irq_src_i;
            src_s2_q    <= src_s1_q;
            filt_prev_q <= filt;
            mask_s1_q   <= irq_mask_i;
            mask_s2_q   <= mask_s1_q;
            mask_d1_q   <= mask_s2_q;
            mask_q      <= mask_d1_q;
            ack_s1_q    <= nmi_if.NMI_ACK;
            ack_s2_q    <= ack_s1_q;
            ack_q       <= ack_s2_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            logic [3:0] filt_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) filt_q <= '0;
                else        filt_q <= src_s2_q;
            end
            assign filt = filt_q;
        end else begin : g_db
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
            for (genvar i = 0; i < 4; i++) begin : g_src
                logic [CNT_W-1:0] cnt_q;
                logic             lvl_q;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        cnt_q <= '0;
                        lvl_q <= 1'b0;
                    end else if (src_s2_q[i] != lvl_q) begin
                        if (cnt_q == LIMIT) begin
                            lvl_q <= src_s2_q[i];
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                assign filt[i] = lvl_q;
            end
        end
    endgenerate

    assign rise = filt & ~filt_prev_q;
    assign cand = pending_q & ~mask_q;

    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) sel = 2'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        nmi_d    = nmi_q;
        nmi_id_d = nmi_id_q;
        clr      = '0;
        unique case (state_q)
            IDLE: begin
                if (|cand) begin
                    nmi_d    = 1'b1;
                    nmi_id_d = sel;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (ack_q) begin
                    nmi_d         = 1'b0;
                    clr[nmi_id_q] = 1'b1;
                    state_d       = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!ack_q) state_d = IDLE;
            end
            default: begin
                nmi_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A new edge on an already pending source is recorded as overflow; set beats clear.
    assign pending_d  = (pending_q & ~clr) | rise;
    assign overflow_d = (ovf_clr_i ? 4'b0000 : overflow_q) | (rise & pending_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            nmi_q      <= 1'b0;
            nmi_id_q   <= 2'd0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            nmi_q      <= nmi_d;
            nmi_id_q   <= nmi_id_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign nmi_if.NMI    = nmi_q;
    assign nmi_if.NMI_ID = nmi_id_q;
    assign pending_o     = pending_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_nmi_requester.sv
// tb/tb_nmi_requester.sv - scoreboard bench for nmi_requester
module tb_nmi_requester;

    logic       clk;
    logic       reset;
    logic [3:0] irq0, mask0, irq1, mask1;
    logic       ovf_clr0, ovf_clr1;
    logic [3:0] pend0, ovf0, pend1, ovf1;
    logic       busy0, busy1;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    nmi_requester_if if0 ();
    nmi_requester_if if1 ();

    nmi_requester u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .irq_src_i  (irq0),
        .irq_mask_i (mask0),
        .ovf_clr_i  (ovf_clr0),
        .nmi_if     (if0.master),
        .pending_o  (pend0),
        .overflow_o (ovf0),
        .busy_o     (busy0)
    );

    nmi_requester #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .irq_src_i  (irq1),
        .irq_mask_i (mask1),
        .ovf_clr_i  (ovf_clr1),
        .nmi_if     (if1.master),
        .pending_o  (pend1),
        .overflow_o (ovf1),
        .busy_o     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_nmi(input string name);
        for (int c = 0; c < 64 && !if0.NMI; c++) step(1);
        chk(name, {31'd0, if0.NMI}, 32'd1);
    endtask

    task automatic service(input string name);
        wait_nmi({name, "_nmi"});
        if0.NMI_ACK = 1'b1;
        for (int c = 0; c < 64 && if0.NMI; c++) step(1);
        chk({name, "_drop"}, {31'd0, if0.NMI}, 32'd0);
        if0.NMI_ACK = 1'b0;
        for (int c = 0; c < 64 && busy0; c++) step(1);
        chk({name, "_idle"}, {31'd0, busy0}, 32'd0);
    endtask

    // Monitor: every new NMI from dut0 must match the next expected source index.
    initial begin
        logic nmi_prev;
        nmi_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (if0.NMI && !nmi_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL nmi_unexpected: got id %0d expected no request at %0t", if0.NMI_ID, $time);
                end else begin
                    chk("nmi_id", {30'd0, if0.NMI_ID}, 32'(exp_q.pop_front()));
                end
            end
            nmi_prev = if0.NMI;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        irq0 = 4'($urandom); mask0 = 4'($urandom); ovf_clr0 = 1'($urandom);
        irq1 = 4'($urandom); mask1 = 4'($urandom); ovf_clr1 = 1'($urandom);
        if0.NMI_ACK = 1'($urandom);
        if1.NMI_ACK = 1'($urandom);
        step(3);
        chk("rst_nmi",  {31'd0, if0.NMI}, 0);
        chk("rst_pend", {28'd0, pend0}, 0);
        chk("rst_ovf",  {28'd0, ovf0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_pend1", {28'd0, pend1}, 0);
        irq0 = 0; mask0 = 0; ovf_clr0 = 0; if0.NMI_ACK = 0;
        irq1 = 0; mask1 = 0; ovf_clr1 = 0; if1.NMI_ACK = 0;
        step(1);
        reset = 1'b1;
        step(8);
        chk("post_rst_nmi",  {31'd0, if0.NMI}, 0);
        chk("post_rst_pend", {28'd0, pend0}, 0);
        chk("post_rst_busy", {31'd0, busy0}, 0);

        // Single request: latency of edge capture, NMI, ACK rise and fall.
        exp_q.push_back(2);
        irq0 = 4'b0100;
        step(3);
        chk("single_pend_k2", {28'd0, pend0}, 0);
        step(1);
        chk("single_pend_k3", {28'd0, pend0}, 4'b0100);
        chk("single_nmi_k3",  {31'd0, if0.NMI}, 0);
        step(1);
        chk("single_nmi_k4",  {31'd0, if0.NMI}, 1);
        chk("single_id_k4",   {30'd0, if0.NMI_ID}, 2);
        chk("single_busy",    {31'd0, busy0}, 1);
        if0.NMI_ACK = 1'b1;
        step(3);
        chk("ack_nmi_m2",  {31'd0, if0.NMI}, 1);
        step(1);
        chk("ack_nmi_m3",  {31'd0, if0.NMI}, 0);
        chk("ack_pend_m3", {28'd0, pend0}, 0);
        chk("ack_busy_m3", {31'd0, busy0}, 1);
        if0.NMI_ACK = 1'b0;
        step(3);
        chk("rel_busy_n2", {31'd0, busy0}, 1);
        step(1);
        chk("rel_busy_n3", {31'd0, busy0}, 0);
        irq0 = 0;
        step(6);

        // Priority and hold.
        exp_q.push_back(1);
        irq0 = 4'b1010;
        wait_nmi("prio_first");
        chk("prio_id_first", {30'd0, if0.NMI_ID}, 1);
        exp_q.push_back(0);
        exp_q.push_back(3);
        irq0 = 4'b1011;
        step(6);
        chk("hold_id",   {30'd0, if0.NMI_ID}, 1);
        chk("hold_pend", {28'd0, pend0}, 4'b1011);
        service("prio_1");
        service("prio_0");
        service("prio_3");
        chk("prio_pend_done", {28'd0, pend0}, 0);
        irq0 = 0;
        step(6);

        // Mask: pending still latched, request held back until unmasked.
        mask0 = 4'b0001;
        irq0 = 4'b0001;
        step(8);
        chk("mask_pend", {28'd0, pend0}, 4'b0001);
        chk("mask_nmi",  {31'd0, if0.NMI}, 0);
        exp_q.push_back(0);
        mask0 = 4'b0000;
        step(4);
        chk("unmask_nmi_e3", {31'd0, if0.NMI}, 0);
        step(1);
        chk("unmask_nmi_e4", {31'd0, if0.NMI}, 1);
        chk("unmask_id",     {30'd0, if0.NMI_ID}, 0);
        service("unmask");
        irq0 = 0;
        step(6);

        // Overflow: second edge while pending, one service only.
        exp_q.push_back(1);
        irq0 = 4'b0010; step(3);
        irq0 = 4'b0000; step(3);
        wait_nmi("ovf_nmi");
        irq0 = 4'b0010; step(3);
        irq0 = 4'b0000; step(6);
        chk("ovf_flag",  {28'd0, ovf0}, 4'b0010);
        chk("ovf_pend",  {28'd0, pend0}, 4'b0010);
        service("ovf");
        step(10);
        chk("ovf_single_nmi", {31'd0, if0.NMI}, 0);
        chk("ovf_pend_done",  {28'd0, pend0}, 0);
        chk("ovf_sticky",     {28'd0, ovf0}, 4'b0010);
        ovf_clr0 = 1'b1; step(1);
        ovf_clr0 = 1'b0; step(1);
        chk("ovf_clr", {28'd0, ovf0}, 0);

        // Reset mid-handshake.
        exp_q.push_back(3);
        irq0 = 4'b1000;
        wait_nmi("rst_mid_nmi");
        step(1);
        reset = 1'b0;
        #2;
        chk("rst_mid_nmi_drop", {31'd0, if0.NMI}, 0);
        chk("rst_mid_busy",     {31'd0, busy0}, 0);
        chk("rst_mid_pend",     {28'd0, pend0}, 0);
        irq0 = 0;
        step(2);
        reset = 1'b1;
        step(12);
        chk("rst_mid_after_nmi",  {31'd0, if0.NMI}, 0);
        chk("rst_mid_after_pend", {28'd0, pend0}, 0);

        // Debounce with four stable cycles required.
        irq1 = 4'b0001; step(3);
        irq1 = 4'b0000; step(10);
        chk("db_glitch_pend", {28'd0, pend1}, 0);
        irq1 = 4'b0001; step(4);
        irq1 = 4'b0000; step(10);
        chk("db_stable_pend", {28'd0, pend1}, 4'b0001);
        chk("db_stable_nmi",  {31'd0, if1.NMI}, 1);
        chk("db_stable_id",   {30'd0, if1.NMI_ID}, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nmi_requester.md
Name: nmi_requester

Overview:
- Initiator side of the core's non-maskable-interrupt handshake (NMI / NMI_ID / NMI_ACK).
- Collects four asynchronous external event sources (push-buttons, board signals), synchronises and debounces them, latches each rising edge as a pending request, and presents one request at a time to the MIPS core by priority.
- Uses a four-phase request/acknowledge handshake with the core.
- Sits in the top level beside the core; runs on the master clock, independent of the core clock.

Parameters:
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a synchronised source level is accepted; 0 bypasses the debounce filter.
- CNT_W, 8, width of the per-source debounce counters; DEBOUNCE_CYCLES must be ≤ 2^CNT_W − 1.

Ports:
- clk  in  1  single clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_src  in  4  asynchronous event inputs; a rising edge requests an NMI.
- irq_mask  in  4  1 = source ignored for new selection; its pending bit is still latched.
- ovf_clr  in  1  synchronous pulse; clears the overflow flags.
- NMI  out  1  request to the core.
- NMI_ID  out  2  index of the source being requested; valid while NMI = 1.
- NMI_ACK  in  1  acknowledge from the core, asynchronous to clk.
- pending  out  4  latched, not-yet-serviced requests.
- overflow  out  4  sticky flag: an edge arrived while that source was already pending.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (reset = 0, asynchronous) clears all state:
  - NMI = 0, NMI_ID = 0, pending = 0, overflow = 0, busy = 0.
  - Synchronisers, filtered levels and counters = 0; FSM = IDLE.
  - Reset asserted mid-handshake drops NMI immediately; no request survives reset.
- Input synchronisation:
  - Each irq_src bit and NMI_ACK passes through a 2-flop synchroniser.
- Debounce, per source:
  - The filtered level follows the synchronised level only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any reversion to the filtered level resets that source's counter to 0.
  - DEBOUNCE_CYCLES = 0: filtered level = synchronised level.
- Edge capture:
  - A 0→1 transition of the filtered level sets pending[i] at the next edge.
  - If pending[i] is already 1, overflow[i] is set instead; pending is not doubled.
  - Set and clear of the same pending bit in the same cycle: set wins, so the bit stays 1.
  - ovf_clr clears overflow; a simultaneous new overflow event wins.
- Selection:
  - Candidates are pending & ~irq_mask.
  - Fixed priority: lowest index wins (source 0 highest).
- FSM:
  - IDLE: if any candidate exists, register NMI = 1 and NMI_ID = selected index, go to REQ.
  - REQ: hold NMI = 1 and NMI_ID stable; they ignore new pending bits and mask changes. When the synchronised ACK = 1, at the next edge drive NMI = 0, clear pending[NMI_ID], go to WAIT_REL.
  - WAIT_REL: NMI = 0. When the synchronised ACK = 0, go to IDLE.
  - NMI_ID keeps its last value outside REQ.
- Latency, DEBOUNCE_CYCLES = 0:
  - irq_src rise sampled at edge k → pending at edge k+3 → NMI high at edge k+4.
  - ACK rise sampled at edge m → NMI low at edge m+3.
  - ACK fall sampled at edge n → IDLE at edge n+3 → earliest next NMI at edge n+4.
- An ACK already high while in IDLE is ignored; only the REQ→WAIT_REL path consumes ACK.
- busy = 1 in REQ and WAIT_REL.
- A source held permanently high generates exactly one request; it must fall and rise again to request again.

Test Plan:
- Reset: drive reset = 0 with random inputs → NMI = 0, pending = 0, overflow = 0, busy = 0. Release reset with all inputs 0 → outputs stay 0.
- Single request, DEBOUNCE_CYCLES = 0: irq_src[2] rises, sampled at edge 10 → pending = 4'b0100 at edge 13, NMI = 1 and NMI_ID = 2 at edge 14. ACK raised at edge 20 → NMI = 0 and pending = 0 at edge 23. ACK dropped → busy = 0 three edges later.
- Priority and hold: irq_src[3] and irq_src[1] rise together → NMI_ID = 1 first. irq_src[0] rises during REQ → NMI_ID stays 1. After the handshake completes → NMI_ID = 0, then 3.
- Mask: irq_mask = 4'b0001, irq_src[0] rises → pending[0] = 1, NMI stays 0. Clear the mask → NMI = 1 with NMI_ID = 0 on the fourth edge after the edge that samples the cleared mask.
- Overflow: irq_src[1] pulses twice while the core withholds ACK → overflow = 4'b0010 and only one request is serviced. ovf_clr → overflow = 0.
- Debounce and reset mid-handshake:
  - DEBOUNCE_CYCLES = 4: a 3-cycle glitch on irq_src[0] → no pending bit. A 4-cycle-stable high → pending[0] = 1.
  - Assert reset while NMI = 1 → NMI = 0 asynchronously, and no NMI after release.
